// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_filter.sv
// Brings the raw PS/2 lines into the clk domain, debounces the PS/2 clock
// and produces a one-cycle pulse on each clean falling edge.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [CW-1:0] stab_cnt;

    // Two-flop synchronisers; both lines idle high on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Stability filter: the filtered clock follows the synchronised clock only
    // after FILTER_LEN consecutive samples disagree with it; fall marks 1->0.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            stab_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                stab_cnt <= '0;
            end else if (stab_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                stab_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frames bytes off the filtered bus, checks parity,
// stop bit and inter-edge timeout, and folds E0/F0 prefixes into flags.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 80000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT);

    logic fall;
    logic data_s;

    ps2_state_t state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_bit_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          pend_break, pend_break_n;
    logic          pend_ext, pend_ext_n;
    logic [7:0]    data_out_n;
    logic          is_break_n, is_ext_n;
    logic          data_valid_n, parity_err_n, frame_err_n;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_sync(data_s)
    );

    // State and datapath registers; a reset drops any partial frame silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            pend_break <= 1'b0;
            pend_ext   <= 1'b0;
            data_out   <= 8'h00;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_bit    <= par_bit_n;
            to_cnt     <= to_cnt_n;
            pend_break <= pend_break_n;
            pend_ext   <= pend_ext_n;
            data_out   <= data_out_n;
            is_break   <= is_break_n;
            is_ext     <= is_ext_n;
            data_valid <= data_valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    // Frame sequencing, error classification, prefix handling and stall watchdog.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        par_bit_n    = par_bit;
        to_cnt_n     = to_cnt;
        pend_break_n = pend_break;
        pend_ext_n   = pend_ext;
        data_out_n   = data_out;
        is_break_n   = is_break;
        is_ext_n     = is_ext;
        data_valid_n = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                to_cnt_n = '0;
                if (fall && !data_s) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_n   = {data_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_n = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_bit_n = data_s;
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_n = ST_IDLE;
                    if (!data_s) begin
                        frame_err_n  = 1'b1;
                        pend_break_n = 1'b0;
                        pend_ext_n   = 1'b0;
                    end else if (!(^shift ^ par_bit)) begin
                        parity_err_n = 1'b1;
                        pend_break_n = 1'b0;
                        pend_ext_n   = 1'b0;
                    end else if (shift == PS2_BREAK) begin
                        pend_break_n = 1'b1;
                    end else if (shift == PS2_EXT) begin
                        pend_ext_n = 1'b1;
                    end else begin
                        data_out_n   = shift;
                        is_break_n   = pend_break;
                        is_ext_n     = pend_ext;
                        data_valid_n = 1'b1;
                        pend_break_n = 1'b0;
                        pend_ext_n   = 1'b0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (state != ST_IDLE) begin
            if (fall) begin
                to_cnt_n = '0;
            end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                state_n      = ST_IDLE;
                to_cnt_n     = '0;
                frame_err_n  = 1'b1;
                pend_break_n = 1'b0;
                pend_ext_n   = 1'b0;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: a table of whole frames plus hand-built
// stall, glitch and mid-frame reset sequences.
module tb_ps2_receiver;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 20;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data_out;
    logic       data_valid;
    logic       is_break;
    logic       is_ext;
    logic       parity_err;
    logic       frame_err;

    int checks;
    int errors;

    int         mon_valid;
    int         mon_perr;
    int         mon_ferr;
    logic [7:0] cap_data;
    logic       cap_brk;
    logic       cap_ext;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        int         exp_valid;
        logic [7:0] exp_data;
        bit         exp_brk;
        bit         exp_ext;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[12];

    ps2_receiver #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_out  (data_out),
        .data_valid(data_valid),
        .is_break  (is_break),
        .is_ext    (is_ext),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the inactive edge; counts only ever grow.
    initial begin
        mon_valid = 0;
        mon_perr  = 0;
        mon_ferr  = 0;
        cap_data  = 8'h00;
        cap_brk   = 1'b0;
        cap_ext   = 1'b0;
    end

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            mon_valid = mon_valid + 1;
            cap_data  = data_out;
            cap_brk   = is_break;
            cap_ext   = is_ext;
        end
        if (parity_err === 1'b1) mon_perr = mon_perr + 1;
        if (frame_err === 1'b1) mon_ferr = mon_ferr + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [10:0] buildFrame(input logic [7:0] code, input bit bad_par,
                                               input bit bad_stop);
        logic par;
        par = ~(^code);
        if (bad_par) par = ~par;
        return {~bad_stop, par, code, 1'b0};
    endfunction

    // Device-side bit timing: data changes while the clock is high, then the clock drops.
    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        int b_valid;
        int b_perr;
        int b_ferr;
        b_valid = mon_valid;
        b_perr  = mon_perr;
        b_ferr  = mon_ferr;
        sendBits(buildFrame(v.code, v.bad_par, v.bad_stop), 11);
        repeat (3 * FILTER_LEN + 10) @(negedge clk);
        checkOutput({tag, " valid_count"}, 32'(mon_valid - b_valid), 32'(v.exp_valid));
        checkOutput({tag, " perr_count"}, 32'(mon_perr - b_perr), 32'(v.exp_perr));
        checkOutput({tag, " ferr_count"}, 32'(mon_ferr - b_ferr), 32'(v.exp_ferr));
        checkOutput({tag, " data_out"}, 32'(data_out), 32'(v.exp_data));
        if (v.exp_valid == 1) begin
            checkOutput({tag, " cap_data"}, 32'(cap_data), 32'(v.exp_data));
            checkOutput({tag, " is_break"}, 32'(cap_brk), 32'(v.exp_brk));
            checkOutput({tag, " is_ext"}, 32'(cap_ext), 32'(v.exp_ext));
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " data_out"}, 32'(data_out), 32'h00);
        checkOutput({tag, " data_valid"}, 32'(data_valid), 32'h0);
        checkOutput({tag, " is_break"}, 32'(is_break), 32'h0);
        checkOutput({tag, " is_ext"}, 32'(is_ext), 32'h0);
        checkOutput({tag, " parity_err"}, 32'(parity_err), 32'h0);
        checkOutput({tag, " frame_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        int b_valid;
        int b_perr;
        int b_ferr;
        vec_t v;

        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;

        //                code   bp  bs  val data   brk ext perr ferr
        vecs[0]  = '{8'h16, 0, 0, 1, 8'h16, 0, 0, 0, 0};
        vecs[1]  = '{8'hF0, 0, 0, 0, 8'h16, 0, 0, 0, 0};
        vecs[2]  = '{8'h1E, 0, 0, 1, 8'h1E, 1, 0, 0, 0};
        vecs[3]  = '{8'h16, 0, 0, 1, 8'h16, 0, 0, 0, 0};
        vecs[4]  = '{8'hE0, 0, 0, 0, 8'h16, 0, 0, 0, 0};
        vecs[5]  = '{8'hF0, 0, 0, 0, 8'h16, 0, 0, 0, 0};
        vecs[6]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 0, 0};
        vecs[7]  = '{8'h16, 1, 0, 0, 8'h75, 0, 0, 1, 0};
        vecs[8]  = '{8'h16, 0, 1, 0, 8'h75, 0, 0, 0, 1};
        vecs[9]  = '{8'hF0, 0, 0, 0, 8'h75, 0, 0, 0, 0};
        vecs[10] = '{8'h16, 1, 0, 0, 8'h75, 0, 0, 1, 0};
        vecs[11] = '{8'h1E, 0, 0, 1, 8'h1E, 0, 0, 0, 0};

        repeat (5) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] stall sequence");
        b_valid = mon_valid;
        b_ferr  = mon_ferr;
        b_perr  = mon_perr;
        sendBits(buildFrame(8'h16, 0, 0), 5);
        repeat (2 * TIMEOUT) @(negedge clk);
        checkOutput("stall ferr_count", 32'(mon_ferr - b_ferr), 32'd1);
        checkOutput("stall valid_count", 32'(mon_valid - b_valid), 32'd0);
        checkOutput("stall perr_count", 32'(mon_perr - b_perr), 32'd0);
        v = '{8'h1E, 0, 0, 1, 8'h1E, 0, 0, 0, 0};
        applyStimulus("after_stall", v);

        $display("[TB] glitch sequence");
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        v = '{8'h16, 0, 0, 1, 8'h16, 0, 0, 0, 0};
        applyStimulus("after_glitch", v);

        $display("[TB] mid-frame reset sequence");
        v = '{8'h1E, 0, 0, 1, 8'h1E, 0, 0, 0, 0};
        applyStimulus("pre_reset", v);
        b_valid = mon_valid;
        b_perr  = mon_perr;
        b_ferr  = mon_ferr;
        sendBits(buildFrame(8'h75, 0, 0), 4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleOutputs("midreset");
        reset = 1'b0;
        repeat (2 * TIMEOUT) @(negedge clk);
        checkOutput("midreset pulses", 32'((mon_valid - b_valid) + (mon_perr - b_perr) + (mon_ferr - b_ferr)), 32'd0);
        v = '{8'h16, 0, 0, 1, 8'h16, 0, 0, 0, 0};
        applyStimulus("after_reset", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Deserialises a PS/2 keyboard stream (ps2_clk/ps2_data, asynchronous, device-driven) into 8-bit scan codes for the position controller. It sits directly upstream of that controller and drives its `data_out`/`data_valid` inputs. It also strips the `E0` (extended) and `F0` (break) prefixes and reports them as flags on the following code. Parity, stop-bit and stall errors are detected and flagged; errored frames are never emitted.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes level.
- `TIMEOUT`, 80000: clk cycles allowed between falling edges inside a frame (2 ms at 40 MHz).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `data_out`  out  8  last valid scan code, held until the next valid one.
- `data_valid`  out  1  one-cycle pulse; `data_out`, `is_break` and `is_ext` are valid in this cycle.
- `is_break`  out  1  code was preceded by `F0`.
- `is_ext`  out  1  code was preceded by `E0`.
- `parity_err`  out  1  one-cycle pulse on a parity failure.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit or a timeout.

## Operation
- **Input conditioning**
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk then passes through a saturating stability counter; the filtered level changes only after `FILTER_LEN` equal samples.
  - `fall` is a 1-cycle pulse when the filtered clock goes 1→0.
  - The synchronised ps2_data is sampled only on `fall`.
- **Frame format:** 11 bits, in order: start 0, 8 data bits LSB first, odd parity, stop 1.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 → DATA, bit counter=0. On `fall` with data=1, stay in IDLE; no error.
  - DATA: on `fall`, shift data into bit 7 of the shift register (right shift) and increment the counter. After the 8th bit → PARITY.
  - PARITY: on `fall`, store the bit → STOP.
  - STOP: on `fall` → IDLE and evaluate the frame:
    - stop=0 → `frame_err`.
    - stop=1 but the XOR of the 8 data bits and the parity bit is 0 → `parity_err`.
    - otherwise the byte is good.
- **Good byte handling**
  - `F0` → set `pend_break`; no output.
  - `E0` → set `pend_ext`; no output.
  - Any other byte → `data_out`=byte, `is_break`=`pend_break`, `is_ext`=`pend_ext`, `data_valid`=1, then clear both pend flags.
- **Timeout**
  - The counter clears on every `fall` and in IDLE, and counts in DATA, PARITY and STOP.
  - When it reaches `TIMEOUT-1`: → IDLE, `frame_err` pulse.
- **Pend flags:** any error (parity, stop or timeout) clears both pend flags.
- **Reset**
  - All outputs 0; `data_out`=8'h00.
  - FSM in IDLE; counters, shift register and pend flags cleared.
  - Filtered clock resets to 1 (bus idle).
  - A reset mid-frame discards the partial frame; no error pulse is produced.

## Timing
- Edge latency: `fall` occurs `FILTER_LEN`+2 cycles after the raw ps2_clk falls.
- Output latency: `data_valid`, `parity_err` and `frame_err` are registered and assert exactly 1 cycle after the `fall` that samples the stop bit.
- Timeout latency: `frame_err` asserts 1 cycle after the counter reaches `TIMEOUT-1`.
- `data_valid`, `parity_err` and `frame_err` are mutually exclusive, at most one pulse per frame.
- No backpressure: the downstream stage must accept each pulse.
- Widths:
  - Bit counter: 4 bits.
  - Timeout counter: $clog2(`TIMEOUT`) bits.
  - Filter counter: $clog2(`FILTER_LEN`+1) bits.
- A timeout and a `fall` in the same cycle: the `fall` wins and the counter clears.

## Structure
- Package `ps2_pkg`:
  - FSM state enum.
  - `PS2_BREAK`=8'hF0 and `PS2_EXT`=8'hE0.
- Sub-module `ps2_filter`: synchroniser, stability filter and falling-edge pulse. Outputs `fall` and the synchronised data.

## Test plan
- **Plain code:** frame for 8'h16, good parity, clean edges → one `data_valid` pulse; `data_out`=16, `is_break`=0, `is_ext`=0.
- **Break prefix:** frames F0 then 1E → one pulse only, `data_out`=1E, `is_break`=1. A subsequent 16 → `is_break`=0.
- **Extended break:** frames E0, F0, 75 → one pulse, `data_out`=75, `is_ext`=1, `is_break`=1.
- **Bad parity and bad stop:**
  - 16 with wrong parity → `parity_err` pulse, no `data_valid`, `data_out` still holds its previous value.
  - A stop bit of 0 → `frame_err`.
- **Stall:** stop the clock after 4 data bits for longer than `TIMEOUT` → `frame_err` once. A following clean 1E frame then decodes correctly.
- **Glitch and reset:**
  - A ps2_clk low glitch of `FILTER_LEN`-1 cycles → no `fall` and no state change.
  - `reset` asserted mid-frame → all outputs 0. The next full frame decodes normally.
